// File: rtl/local_bht_param_if.sv
// Fetch/execute side of the local branch history predictor.
// The master modport is the pipeline side and the slave modport is the predictor.
interface local_bht_param_if #(
  parameter int unsigned HIST_BITS = 10
);
  logic [15:0]          read_pc;
  logic                 read_valid;
  logic                 prediction;
  logic                 pred_valid;
  logic [HIST_BITS-1:0] pred_hist;
  logic                 write;
  logic [15:0]          write_pc;
  logic                 taken;
  logic                 ready;

  modport master (
    output read_pc, read_valid, write, write_pc, taken,
    input  prediction, pred_valid, pred_hist, ready
  );

  modport slave (
    input  read_pc, read_valid, write, write_pc, taken,
    output prediction, pred_valid, pred_hist, ready
  );
endinterface

// File: rtl/local_bht_param.sv
// Two-level local branch predictor.
// A per-PC history table selects a saturating counter in a shared pattern table.
// After every reset, an init sweep clears both tables before the predictor accepts
// reads or updates.
// Constraints: HIST_BITS >= 2 and INDEX_BITS <= 15.
module local_bht_param #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned HIST_BITS  = 10,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned CTR_INIT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  local_bht_param_if.slave       bus
);

  localparam int unsigned HistEntries = 2 ** INDEX_BITS;
  localparam int unsigned CtrEntries  = 2 ** HIST_BITS;
  localparam int unsigned CntBits     = (INDEX_BITS > HIST_BITS) ? INDEX_BITS : HIST_BITS;

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                state_q;
  logic [CntBits-1:0]    sweep_cnt_q;
  logic                  ready_q;
  logic                  pred_valid_q;
  logic                  prediction_q;
  logic [HIST_BITS-1:0]  pred_hist_q;

  logic [HIST_BITS-1:0]  hist_tbl [HistEntries];
  logic [CTR_BITS-1:0]   ctr_tbl  [CtrEntries];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [HIST_BITS-1:0]  rd_hist;
  logic                  rd_pred;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [HIST_BITS-1:0]  wr_hist;
  logic [CTR_BITS-1:0]   wr_ctr;
  logic [CTR_BITS-1:0]   wr_ctr_next;
  logic [HIST_BITS-1:0]  wr_hist_next;
  logic                  unused_pc;

  // Only pc[INDEX_BITS:1] is meaningful; the remaining PC bits are intentionally dropped.
  assign unused_pc = ^{bus.read_pc, bus.write_pc};

  // Table lookups and the saturating/shift update values.
  always_comb begin
    rd_idx       = bus.read_pc[INDEX_BITS:1];
    rd_hist      = hist_tbl[rd_idx];
    rd_pred      = ctr_tbl[rd_hist][CTR_BITS-1];
    wr_idx       = bus.write_pc[INDEX_BITS:1];
    wr_hist      = hist_tbl[wr_idx];
    wr_ctr       = ctr_tbl[wr_hist];
    wr_ctr_next  = wr_ctr;
    if (bus.taken) begin
      if (wr_ctr != '1) wr_ctr_next = wr_ctr + 1'b1;
    end else begin
      if (wr_ctr != '0) wr_ctr_next = wr_ctr - 1'b1;
    end
    wr_hist_next = {wr_hist[HIST_BITS-2:0], bus.taken};
  end

  // Table storage.
  // The init sweep clears both tables; in the ready state, updates from execute are applied.
  // Reads are registered in the FSM block at the same edge, so they observe pre-write contents.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      if (32'(sweep_cnt_q) < HistEntries) hist_tbl[sweep_cnt_q[INDEX_BITS-1:0]] <= '0;
      if (32'(sweep_cnt_q) < CtrEntries) ctr_tbl[sweep_cnt_q[HIST_BITS-1:0]] <= CTR_BITS'(CTR_INIT);
    end else if (bus.write) begin
      ctr_tbl[wr_hist] <= wr_ctr_next;
      hist_tbl[wr_idx] <= wr_hist_next;
    end
  end

  // Sweep/ready FSM with registered prediction outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      sweep_cnt_q  <= '0;
      ready_q      <= 1'b0;
      pred_valid_q <= 1'b0;
      prediction_q <= 1'b0;
      pred_hist_q  <= '0;
    end else begin
      pred_valid_q <= 1'b0;
      unique case (state_q)
        StInit: begin
          sweep_cnt_q <= sweep_cnt_q + 1'b1;
          if (sweep_cnt_q == '1) begin
            state_q <= StReady;
            ready_q <= 1'b1;
          end
        end
        StReady: begin
          if (bus.read_valid) begin
            pred_valid_q <= 1'b1;
            pred_hist_q  <= rd_hist;
            prediction_q <= rd_pred;
          end
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.pred_valid = pred_valid_q;
  assign bus.prediction = prediction_q;
  assign bus.pred_hist  = pred_hist_q;

endmodule

// File: tb/tb_local_bht_param.sv
// Bench for local_bht_param.
// An abstract model, built from arrays and plain arithmetic, is compared with the
// DUT outputs on every falling edge.
// Directed sequences add literal checks that pin the expected values themselves.
module tb_local_bht_param;
  localparam int unsigned IB = 6;
  localparam int unsigned HB = 10;
  localparam int unsigned CB = 2;
  localparam int unsigned CI = 1;
  localparam int unsigned NSWEEP = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  local_bht_param_if #(.HIST_BITS(HB)) bus ();

  local_bht_param #(
    .INDEX_BITS(IB),
    .HIST_BITS (HB),
    .CTR_BITS  (CB),
    .CTR_INIT  (CI)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tables as int arrays, holding their post-sweep contents from reset onward.
  int unsigned hist_m [1 << IB];
  int unsigned ctr_m  [1 << HB];
  int unsigned cycles_m = 0;
  bit          ready_m = 0;
  bit          exp_valid = 0;
  bit          exp_pred = 0;
  int unsigned exp_hist = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_m  = 0;
      ready_m   = 0;
      exp_valid = 0;
      exp_pred  = 0;
      exp_hist  = 0;
      foreach (hist_m[i]) hist_m[i] = 0;
      foreach (ctr_m[i]) ctr_m[i] = CI;
    end else begin
      exp_valid = 0;
      if (ready_m) begin
        if (bus.read_valid) begin
          int unsigned ri;
          ri        = (int'(bus.read_pc) / 2) % (1 << IB);
          exp_hist  = hist_m[ri];
          exp_pred  = ctr_m[exp_hist] >= (1 << (CB - 1));
          exp_valid = 1;
        end
        if (bus.write) begin
          int unsigned wi, h;
          wi = (int'(bus.write_pc) / 2) % (1 << IB);
          h  = hist_m[wi];
          if (bus.taken) begin
            if (ctr_m[h] < (1 << CB) - 1) ctr_m[h] = ctr_m[h] + 1;
          end else begin
            if (ctr_m[h] > 0) ctr_m[h] = ctr_m[h] - 1;
          end
          hist_m[wi] = (h * 2 + (bus.taken ? 1 : 0)) % (1 << HB);
        end
      end
      if (cycles_m < NSWEEP) cycles_m++;
      ready_m = (cycles_m >= NSWEEP);
    end
  end

  bit checking = 0;

  always @(negedge clk) begin
    if (checking) begin
      chk("ready", 32'(bus.ready), 32'(ready_m));
      chk("pred_valid", 32'(bus.pred_valid), 32'(exp_valid));
      chk("pred_hist", 32'(bus.pred_hist), exp_hist);
      chk("prediction", 32'(bus.prediction), 32'(exp_pred));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rv, input logic [15:0] rpc, input bit w,
                       input logic [15:0] wpc, input bit tk);
    bus.read_valid = rv;
    bus.read_pc    = rpc;
    bus.write      = w;
    bus.write_pc   = wpc;
    bus.taken      = tk;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic rd(input logic [15:0] pc);
    drive(1'b1, pc, 1'b0, 16'h0, 1'b0);
    step();
    idle();
  endtask

  task automatic wr(input logic [15:0] pc, input bit tk);
    drive(1'b0, 16'h0, 1'b1, pc, tk);
    step();
    idle();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.ready && n < 2000);
  endtask

  initial begin
    int n;
    idle();
    #1 rst_n = 1'b0;
    step(); step(); step();
    // Read and write requests held high through the whole sweep must be ignored.
    drive(1'b1, 16'h3000, 1'b1, 16'h3000, 1'b1);
    rst_n    = 1'b1;
    checking = 1;
    wait_ready(n);
    chk("sweep_len_1", n, NSWEEP);
    rd(16'h3000);
    chk("t1_valid", 32'(bus.pred_valid), 1);
    chk("t1_hist", 32'(bus.pred_hist), 0);
    chk("t1_pred", 32'(bus.prediction), 0);

    // A single taken update to index 0.
    wr(16'h3000, 1'b1);
    rd(16'h3002);
    chk("t3_alias_hist", 32'(bus.pred_hist), 0);
    chk("t3_alias_pred", 32'(bus.prediction), 1);
    rd(16'h3000);
    chk("t3_hist", 32'(bus.pred_hist), 32'h001);
    chk("t3_pred", 32'(bus.prediction), 0);

    // History saturates at all-ones, and counter[0x3FF] saturates at 3.
    for (int i = 0; i < 13; i++) wr(16'h3004, 1'b1);
    rd(16'h3004);
    chk("t4_hist_sat", 32'(bus.pred_hist), 32'h3FF);
    chk("t4_pred_sat", 32'(bus.prediction), 1);
    wr(16'h3004, 1'b0);
    rd(16'h3004);
    chk("t4_hist_nt", 32'(bus.pred_hist), 32'h3FE);
    chk("t4_pred_nt", 32'(bus.prediction), 0);

    // A reset while pred_valid is high, followed by a reset pulse in the middle of the sweep.
    rd(16'h3000);
    chk("t6_pv_before", 32'(bus.pred_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_pv_reset", 32'(bus.pred_valid), 0);
    chk("t6_rdy_reset", 32'(bus.ready), 0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 500; i++) step();
    chk("t6_rdy_mid", 32'(bus.ready), 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rdy_pulse", 32'(bus.ready), 0);
    chk("t6_pv_pulse", 32'(bus.pred_valid), 0);
    step();
    rst_n = 1'b1;
    wait_ready(n);
    chk("sweep_len_2", n, NSWEEP);
    rd(16'h3000);
    chk("t6_hist", 32'(bus.pred_hist), 0);
    chk("t6_pred", 32'(bus.prediction), 0);

    // A write and a read to the same index in the same cycle: the read sees pre-write state.
    drive(1'b1, 16'h3000, 1'b1, 16'h3000, 1'b1);
    step();
    idle();
    chk("t5_same_hist", 32'(bus.pred_hist), 0);
    chk("t5_same_pred", 32'(bus.prediction), 0);
    rd(16'h3000);
    chk("t5_next_hist", 32'(bus.pred_hist), 32'h001);
    step();
    chk("t5_pv_drop", 32'(bus.pred_valid), 0);

    step();
    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/local_bht_param.md
Name: local_bht_param

Overview:
Parametrised two-level local branch history predictor for the fetch stage. A per-PC history table (2^INDEX_BITS entries of HIST_BITS taken/not-taken bits) indexes a shared pattern table (2^HIST_BITS saturating counters of CTR_BITS). It improves on the fixed-size predictor in four ways: configurable geometry, a taken-bit shift-register history, a registered prediction with a valid strobe, and a post-reset initialisation sweep that clears both tables.

Parameters:
INDEX_BITS, 6, history table index width; the index is pc[INDEX_BITS:1]
HIST_BITS, 10, history length; the pattern table has 2^HIST_BITS entries
CTR_BITS, 2, saturating counter width (>=1)
CTR_INIT, 1, counter value written during the init sweep (weakly not-taken)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
read_pc  in  16  fetch PC to predict
read_valid  in  1  request a prediction for read_pc
prediction  out  1  1 = taken; MSB of the selected counter
pred_valid  out  1  prediction and pred_hist are valid this cycle
pred_hist  out  HIST_BITS  history used for the prediction (for the pipeline to carry)
write  in  1  resolve/update strobe from execute
write_pc  in  16  PC of the resolved branch
taken  in  1  resolved outcome
ready  out  1  1 = init sweep done; tables usable

Behaviour:
- Reset (rst_n low, asynchronous): ready=0, pred_valid=0, prediction=0, pred_hist=0, FSM=INIT, sweep counter=0. Table contents are don't-care until the sweep completes.
- FSM INIT:
  - Each cycle, write history[cnt]=0 when cnt < 2^INDEX_BITS, and counter[cnt]=CTR_INIT when cnt < 2^HIST_BITS.
  - cnt increments; N = 2^max(INDEX_BITS,HIST_BITS).
  - After the cycle with cnt=N-1, go to READY. ready=1 starting N cycles after rst_n deasserts.
  - read_valid and write are ignored in INIT; pred_valid stays 0.
- FSM READY: stays until reset. A reset in mid-sweep or in READY returns to INIT with cnt=0 and a full sweep.
- Read, 1-cycle latency:
  - Triggered by read_valid=1 in READY at edge t.
  - At t+1: pred_valid=1, pred_hist=history[read_pc[INDEX_BITS:1]], prediction=counter[pred_hist][CTR_BITS-1].
  - pred_valid=0 in any cycle not preceded by an accepted read. prediction and pred_hist hold their last value when pred_valid=0.
- Update, on write=1 in READY:
  - Let i=write_pc[INDEX_BITS:1] and h=history[i].
  - Counter: counter[h] += 1 if taken, saturating at 2^CTR_BITS-1; counter[h] -= 1 if not taken, saturating at 0.
  - History: history[i] <= {h[HIST_BITS-2:0], taken}; the oldest bit is dropped and the LSB is the newest outcome.
- Simultaneous read and write, any indices including the same one: the read returns pre-write state, with no bypass. The write completes normally.
- PC bit 0 and bits above INDEX_BITS are ignored. Distinct PCs aliasing to one index share history.

Test Plan (defaults: sweep N=1024):
- Release rst_n -> ready=0 for exactly 1024 cycles, then 1. Read 0x3000 -> next cycle pred_valid=1, pred_hist=0x000, prediction=0.
- Assert write and read_valid during INIT with write_pc=0x3000, taken=1 -> no pred_valid. After ready, read 0x3000 -> pred_hist=0x000, confirming the write was ignored.
- One taken write to 0x3000 -> history[0]=0x001 and counter[0x000]=2. Read 0x3002 (index 1, history 0) -> prediction=1. Read 0x3000 -> pred_hist=0x001, prediction=0.
- 13 consecutive taken writes to 0x3004 -> history saturates at 0x3FF after 10 writes, and counter[0x3FF] goes 1→2→3→3. Read -> prediction=1. Then one not-taken write -> history=0x3FE and counter[0x3FF]=2.
- Same-cycle write(0x3000, taken=1) and read(0x3000) from fresh state -> pred_hist=0x000. A read next cycle -> pred_hist=0x001.
- Train 0x3000, then pulse rst_n low at sweep cycle 500 of a second reset -> ready=0 and pred_valid=0 immediately. Full 1024-cycle sweep after release, then read 0x3000 -> pred_hist=0x000, prediction=0.
